// File: rtl/smallcpu_pkg.sv
// smallcpu_pkg: shared width default and ALU opcode constants for the accumulator CPU
package smallcpu_pkg;
  localparam int N_DEFAULT = 16;
  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_XOR    = 4'd1;
  localparam logic [3:0] OP_OR     = 4'd2;
  localparam logic [3:0] OP_AND    = 4'd3;
  localparam logic [3:0] OP_SEQ    = 4'd4;
  localparam logic [3:0] OP_SLT    = 4'd5;
  localparam logic [3:0] OP_SL     = 4'd6;
  localparam logic [3:0] OP_SR     = 4'd7;
  localparam logic [3:0] OP_IMM    = 4'd8;
  localparam logic [3:0] OP_IFJUMP = 4'd9;
  localparam logic [3:0] OP_STORE  = 4'd10;
  localparam logic [3:0] OP_MOVE   = 4'd11;
endpackage

// File: rtl/sync_ram.sv
// sync_ram: word RAM with synchronous clear-on-reset, synchronous write and asynchronous read
module sync_ram #(
  parameter int N      = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [N-1:0]      wdata,
  input  logic              we,
  output logic [N-1:0]      rdata
);
  logic [N-1:0] mem [2**ADDR_W];
  // reset wipes every word and wins over a simultaneous write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end
  assign rdata = mem[addr];
endmodule

// File: rtl/alu_memory.sv
// alu_memory: data RAM plus combinational ALU whose operand B is the RAM read data
module alu_memory
  import smallcpu_pkg::*;
#(
  parameter int N      = N_DEFAULT,
  parameter int ADDR_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] mem_addr,
  input  logic [N-1:0] mem_wdata,
  input  logic         mem_we,
  output logic [N-1:0] mem_rdata,
  input  logic [N-1:0] alu_a,
  input  logic [3:0]   alu_op,
  output logic [N-1:0] alu_result
);
  logic unused_addr_hi;
  logic [N-1:0] b;
  logic big_shift;
  assign unused_addr_hi = ^mem_addr[N-1:ADDR_W];
  sync_ram #(.N(N), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .addr  (mem_addr[ADDR_W-1:0]),
    .wdata (mem_wdata),
    .we    (mem_we),
    .rdata (mem_rdata)
  );
  assign b = mem_rdata;
  assign big_shift = b >= N'(N);
  // opcode decode; codes 8-15 forward the memory word so the core can load it
  always_comb begin
    alu_result = b;
    case (alu_op)
      OP_ADD: alu_result = alu_a + b;
      OP_XOR: alu_result = alu_a ^ b;
      OP_OR:  alu_result = alu_a | b;
      OP_AND: alu_result = alu_a & b;
      OP_SEQ: alu_result = {{(N-1){1'b0}}, alu_a == b};
      OP_SLT: alu_result = {{(N-1){1'b0}}, alu_a < b};
      OP_SL:  alu_result = big_shift ? '0 : alu_a << b;
      OP_SR:  alu_result = big_shift ? '0 : alu_a >> b;
      default: alu_result = b;
    endcase
  end
endmodule

// File: tb/tb_alu_memory.sv
// tb_alu_memory: directed vector and sequence checks for alu_memory
module tb_alu_memory;
  logic        clk = 0;
  logic        rst;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, alu_a, alu_result;
  logic        mem_we;
  logic [3:0]  alu_op;
  int checks = 0;
  int errors = 0;

  alu_memory dut (
    .clk        (clk),
    .rst        (rst),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .alu_a      (alu_a),
    .alu_op     (alu_op),
    .alu_result (alu_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] addr;
    logic [15:0] a;
    logic [3:0]  op;
    logic [15:0] exp_rdata;
    logic [15:0] exp_result;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data);
    @(negedge clk);
    mem_addr = addr; mem_wdata = data; mem_we = 1;
    @(posedge clk);
    #1 mem_we = 0;
  endtask

  task automatic rd(input string name, input logic [15:0] addr, input logic [15:0] exp);
    @(negedge clk);
    mem_addr = addr;
    #1 chk(name, mem_rdata, exp);
  endtask

  initial begin
    vecs[0]  = '{"add_wrap",  16'd7,  16'h0001, 4'd0,  16'hFFFF, 16'h0000};
    vecs[1]  = '{"xor",       16'd7,  16'h0001, 4'd1,  16'hFFFF, 16'hFFFE};
    vecs[2]  = '{"and",       16'd7,  16'h0001, 4'd3,  16'hFFFF, 16'h0001};
    vecs[3]  = '{"or",        16'd7,  16'h0001, 4'd2,  16'hFFFF, 16'hFFFF};
    vecs[4]  = '{"seq_eq",    16'd10, 16'h0005, 4'd4,  16'h0005, 16'h0001};
    vecs[5]  = '{"seq_ne",    16'd10, 16'h0006, 4'd4,  16'h0005, 16'h0000};
    vecs[6]  = '{"slt_lt",    16'd10, 16'h0004, 4'd5,  16'h0005, 16'h0001};
    vecs[7]  = '{"slt_eq",    16'd10, 16'h0005, 4'd5,  16'h0005, 16'h0000};
    vecs[8]  = '{"slt_uns",   16'd10, 16'hFFFF, 4'd5,  16'h0005, 16'h0000};
    vecs[9]  = '{"sl1",       16'd11, 16'h8001, 4'd6,  16'h0001, 16'h0002};
    vecs[10] = '{"sr1",       16'd11, 16'h8001, 4'd7,  16'h0001, 16'h4000};
    vecs[11] = '{"sl16",      16'd12, 16'h8001, 4'd6,  16'h0010, 16'h0000};
    vecs[12] = '{"sr16",      16'd12, 16'h8001, 4'd7,  16'h0010, 16'h0000};
    vecs[13] = '{"sr15",      16'd13, 16'h8001, 4'd7,  16'h000F, 16'h0001};
    vecs[14] = '{"sl15",      16'd13, 16'h8001, 4'd6,  16'h000F, 16'h8000};
    vecs[15] = '{"op12_load", 16'd14, 16'h1234, 4'd12, 16'h0042, 16'h0042};
    vecs[16] = '{"op8_pass",  16'd14, 16'h0000, 4'd8,  16'h0042, 16'h0042};
    vecs[17] = '{"op15_pass", 16'd7,  16'h0000, 4'd15, 16'hFFFF, 16'hFFFF};

    rst = 1; mem_we = 0; mem_addr = 0; mem_wdata = 0; alu_a = 16'h1111; alu_op = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    rd("rst_addr0", 16'd0, 16'h0000);
    rd("rst_addr5", 16'd5, 16'h0000);
    rd("rst_addr255", 16'd255, 16'h0000);
    chk("rst_alu_add", alu_result, 16'h1111);

    wr(16'd3, 16'h1234);
    rd("wr_addr3", 16'd3, 16'h1234);
    wr(16'h0103, 16'h00FF);
    rd("alias_addr3", 16'd3, 16'h00FF);
    rd("alias_addr103", 16'h0103, 16'h00FF);

    @(negedge clk);
    mem_addr = 16'd3; mem_wdata = 16'hBEEF; mem_we = 1;
    #1 chk("rdw_old", mem_rdata, 16'h00FF);
    @(posedge clk);
    #1 mem_we = 0;
    chk("rdw_new", mem_rdata, 16'hBEEF);

    @(negedge clk);
    rst = 1; mem_addr = 16'd2; mem_wdata = 16'hABCD; mem_we = 1;
    @(posedge clk);
    #1 chk("rst_beats_wr", mem_rdata, 16'h0000);
    mem_we = 0;
    @(posedge clk);
    #1 rst = 0;
    rd("rst_clear_addr3", 16'd3, 16'h0000);
    wr(16'd2, 16'h5555);
    rd("wr_after_rst", 16'd2, 16'h5555);

    wr(16'd7, 16'hFFFF);
    wr(16'd10, 16'h0005);
    wr(16'd11, 16'h0001);
    wr(16'd12, 16'h0010);
    wr(16'd13, 16'h000F);
    wr(16'd14, 16'h0042);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      mem_addr = vecs[i].addr; alu_a = vecs[i].a; alu_op = vecs[i].op;
      #1;
      chk({vecs[i].name, "_rdata"}, mem_rdata, vecs[i].exp_rdata);
      chk(vecs[i].name, alu_result, vecs[i].exp_result);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_memory.md
# alu_memory

Combined datapath block for the 16-bit accumulator CPU: a word-addressed RAM with synchronous write and combinational read, plus a combinational ALU whose operand B is the RAM read data. The CPU core drives the address, write data, write enable, accumulator and opcode, and latches `alu_result` into its accumulator on the next rising edge. The same RAM definition also serves as the CPU's instruction memory, with write enable tied low.

## Interface
Parameters:
- `N`, 16: data and address width in bits.
- `ADDR_W`, 8: implemented address bits; depth is 2^ADDR_W words.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `mem_addr`  in  N: word address; only `mem_addr[ADDR_W-1:0]` is used, upper bits ignored (aliasing).
- `mem_wdata`  in  N: write data.
- `mem_we`  in  1: write enable.
- `mem_rdata`  out  N: combinational read data at `mem_addr`.
- `alu_a`  in  N: operand A (accumulator).
- `alu_op`  in  4: opcode.
- `alu_result`  out  N: combinational ALU result; operand B is `mem_rdata`.

## Operation
- RAM write: at a rising edge with `rst`=0 and `mem_we`=1, `mem[mem_addr[ADDR_W-1:0]] <= mem_wdata`.
- RAM read: `mem_rdata = mem[mem_addr[ADDR_W-1:0]]`, asynchronous.
- Reset: at a rising edge with `rst`=1, every word is cleared to 0. Reset has priority over a simultaneous write, so that write is dropped.
- ALU, with B = `mem_rdata` and all arithmetic modulo 2^N, unsigned:
  - 0 ADD: A+B, carry discarded.
  - 1 XOR: A^B.
  - 2 OR: A|B.
  - 3 AND: A&B.
  - 4 SEQ: 1 if A==B, else 0.
  - 5 SLT: 1 if A<B unsigned, else 0.
  - 6 SL: A << B, logical; result 0 if B >= N.
  - 7 SR: A >> B, logical, zero-fill; result 0 if B >= N.
  - 8-15: pass B unchanged. The CPU core handles IMM, IFJUMP, STORE and MOVE itself; codes 12-15 act as loads.
- Results of SEQ and SLT are zero-extended to N bits.

## Timing
- Read and ALU paths are combinational, with zero-cycle latency from `mem_addr`, `alu_a` and `alu_op` to outputs.
- Write is visible on `mem_rdata` and `alu_result` immediately after the writing edge.
- Read-during-write to the same address in the same cycle: `mem_rdata` shows old data until the edge, then new data.
- Outputs have no reset value of their own. After a reset edge, `mem_rdata` = 0 for every address, so `alu_result` equals the opcode applied to (`alu_a`, 0).
- No handshake; every cycle is valid.
- Reset held for several cycles keeps the memory at 0. Writes resume on the first edge with `rst`=0.

## Structure
- Shared package `smallcpu_pkg` holds:
  - `N` default.
  - 4-bit opcode constants: ADD=0, XOR=1, OR=2, AND=3, SEQ=4, SLT=5, SL=6, SR=7, IMM=8, IFJUMP=9, STORE=10, MOVE=11.
- Natural sub-module: `sync_ram` (array, reset clear, write port, async read). The ALU is a combinational case statement in the top.

## Test plan
- Reset, then read addresses 0, 5 and 255 -> `mem_rdata`=0 at each.
- Write 0x1234 to address 3, then read address 3 -> 0x1234. Write 0x00FF to address 0x0103 (aliasing) -> address 3 reads 0x00FF.
- Address 7 holds 0xFFFF, A=1, ADD -> 0x0000. XOR -> 0xFFFE. AND -> 0x0001. OR -> 0xFFFF.
- B=5, A=5, SEQ -> 1. A=4, SLT -> 1. A=0xFFFF, SLT -> 0 (unsigned compare).
- A=0x8001:
  - B=1, SL -> 0x0002.
  - B=1, SR -> 0x4000.
  - B=16, SL -> 0.
  - B=15, SR -> 0x0001.
- Same-edge `rst`=1 and `mem_we`=1 to address 2 with 0xABCD -> address 2 reads 0. Op 12 with B=0x0042 -> `alu_result`=0x0042.
